dcache_nway: RTL and testbench



---
 rtl/dcache_nway_if.sv | 19 +
 rtl/dcache_nway.sv | 210 +++++++++++++++++++++
 tb/tb_dcache_nway.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_nway_if.sv
// Datapath-side and memory-side signals of the N-way data cache.
// The slave view belongs to the cache; the master view is its environment.
interface dcache_nway_if;
  logic        dmemREN, dmemWEN, halt;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit, flushed;
  logic [31:0] dmemload;
  logic        dREN, dWEN, dwait;
  logic [31:0] daddr, dstore, dload;

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );
endinterface

// File: rtl/dcache_nway.sv
// Write-back, write-allocate N-way data cache with true-LRU ages,
// invalid-way-first victims, and a flush that dumps hit/miss counts at halt.
module dcache_nway #(
  parameter int          SETS          = 8,
  parameter int          WAYS          = 2,
  parameter int          WORDS_PER_BLK = 2,
  parameter logic [31:0] CNT_ADDR      = 32'h00003100
) (
  input logic          CLK,
  input logic          RST,
  dcache_nway_if.slave bus
);
  localparam int BOFF = $clog2(WORDS_PER_BLK);
  localparam int IDX  = $clog2(SETS);
  localparam int AW   = $clog2(WAYS);
  localparam int TAGW = 30 - BOFF - IDX;

  typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH, CNT_HIT, CNT_MISS, DONE} state_t;
  typedef logic [WAYS-1:0][AW-1:0] ages_t;

  state_t state, state_nx, prev_state;

  logic [SETS-1:0][WAYS-1:0]           valid, dirty;
  logic [SETS-1:0][WAYS-1:0][TAGW-1:0] tags;
  ages_t [SETS-1:0]                    age;
  logic [31:0] data [SETS][WAYS][WORDS_PER_BLK];

  logic [TAGW-1:0] m_tag;
  logic [IDX-1:0]  m_idx, fset;
  logic [AW-1:0]   vic, fway;
  logic [BOFF-1:0] wcnt;
  logic [31:0]     hits, misses;

  logic [TAGW-1:0] req_tag;
  logic [IDX-1:0]  req_idx;
  logic [BOFF-1:0] req_off;
  logic            req, hit, dhit, miss, last_word, last_line, fl_dirty;
  logic [AW-1:0]   hit_way, vic_sel;
  logic            dren, dwen, flushed;
  logic [31:0]     daddr, dstore, dmemload;
  logic            unused;

  assign req_tag   = bus.dmemaddr[31 -: TAGW];
  assign req_idx   = bus.dmemaddr[2+BOFF +: IDX];
  assign req_off   = bus.dmemaddr[2 +: BOFF];
  assign req       = bus.dmemREN ^ bus.dmemWEN;
  assign last_word = (wcnt == BOFF'(WORDS_PER_BLK-1));
  assign last_line = (fset == IDX'(SETS-1)) && (fway == AW'(WAYS-1));
  assign fl_dirty  = valid[fset][fway] && dirty[fset][fway];
  assign unused    = ^bus.dmemaddr[1:0];

  // Accessed way becomes MRU; ways younger than it age by one.
  function automatic ages_t touch(input ages_t a, input logic [AW-1:0] t);
    touch = a;
    for (int w = 0; w < WAYS; w++)
      if (AW'(w) == t)    touch[w] = '0;
      else if (a[w] < a[t]) touch[w] = a[w] + 1'b1;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = AW'(w);
      end
  end

  // Descending scans so the lowest index wins; an invalid way overrides the LRU way.
  always_comb begin
    vic_sel = '0;
    for (int w = WAYS-1; w >= 0; w--)
      if (age[req_idx][w] == AW'(WAYS-1)) vic_sel = AW'(w);
    for (int w = WAYS-1; w >= 0; w--)
      if (!valid[req_idx][w]) vic_sel = AW'(w);
  end

  always_comb begin
    state_nx = state;
    dhit     = 1'b0;
    miss     = 1'b0;
    dmemload = '0;
    dren     = 1'b0;
    dwen     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    flushed  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.halt) state_nx = FLUSH;
        else if (req && hit) begin
          dhit     = 1'b1;
          dmemload = data[req_idx][hit_way][req_off];
        end else if (req) begin
          miss     = 1'b1;
          state_nx = (valid[req_idx][vic_sel] && dirty[req_idx][vic_sel]) ? WB : FILL;
        end
      end
      WB: begin
        dwen   = 1'b1;
        daddr  = {tags[m_idx][vic], m_idx, wcnt, 2'b00};
        dstore = data[m_idx][vic][wcnt];
        if (!bus.dwait && last_word) state_nx = FILL;
      end
      FILL: begin
        dren  = 1'b1;
        daddr = {m_tag, m_idx, wcnt, 2'b00};
        if (!bus.dwait && last_word) state_nx = IDLE;
      end
      FLUSH: begin
        if (fl_dirty) begin
          dwen   = 1'b1;
          daddr  = {tags[fset][fway], fset, wcnt, 2'b00};
          dstore = data[fset][fway][wcnt];
          if (!bus.dwait && last_word && last_line) state_nx = CNT_HIT;
        end else if (last_line) state_nx = CNT_HIT;
      end
      CNT_HIT: begin
        dwen   = 1'b1;
        daddr  = CNT_ADDR;
        dstore = hits;
        if (!bus.dwait) state_nx = CNT_MISS;
      end
      CNT_MISS: begin
        dwen   = 1'b1;
        daddr  = CNT_ADDR + 32'd4;
        dstore = misses;
        if (!bus.dwait) state_nx = DONE;
      end
      DONE:    flushed = 1'b1;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      prev_state <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      tags       <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) age[s][w] <= AW'(w);
      m_tag  <= '0;
      m_idx  <= '0;
      vic    <= '0;
      wcnt   <= '0;
      fset   <= '0;
      fway   <= '0;
      hits   <= '0;
      misses <= '0;
    end else begin
      state      <= state_nx;
      prev_state <= state;
      case (state)
        IDLE: begin
          if (dhit) begin
            if (bus.dmemWEN) dirty[req_idx][hit_way] <= 1'b1;
            age[req_idx] <= touch(age[req_idx], hit_way);
            // The replayed hit after a fill belongs to the miss already counted.
            if (prev_state != FILL) hits <= hits + 32'd1;
          end else if (miss) begin
            m_tag  <= req_tag;
            m_idx  <= req_idx;
            vic    <= vic_sel;
            wcnt   <= '0;
            misses <= misses + 32'd1;
          end
        end
        WB: if (!bus.dwait) wcnt <= wcnt + 1'b1;
        FILL: if (!bus.dwait) begin
          wcnt <= wcnt + 1'b1;
          if (last_word) begin
            tags[m_idx][vic]  <= m_tag;
            valid[m_idx][vic] <= 1'b1;
            dirty[m_idx][vic] <= 1'b0;
            age[m_idx]        <= touch(age[m_idx], vic);
          end
        end
        FLUSH: if (!fl_dirty || !bus.dwait) begin
          if (fl_dirty) wcnt <= wcnt + 1'b1;
          if (!fl_dirty || last_word) begin
            valid[fset][fway] <= 1'b0;
            dirty[fset][fway] <= 1'b0;
            fway <= fway + 1'b1;
            if (fway == AW'(WAYS-1)) fset <= fset + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage needs no reset: valid bits gate every use.
  always_ff @(posedge CLK) begin
    if (dhit && bus.dmemWEN)
      data[req_idx][hit_way][req_off] <= bus.dmemstore;
    else if (state == FILL && !bus.dwait)
      data[m_idx][vic][wcnt] <= bus.dload;
  end

  assign bus.dhit     = dhit;
  assign bus.dmemload = dmemload;
  assign bus.flushed  = flushed;
  assign bus.dREN     = dren;
  assign bus.dWEN     = dwen;
  assign bus.daddr    = daddr;
  assign bus.dstore   = dstore;
endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench: a 2-way cache (u0) and a 4-way cache (u4) share stimulus;
// memory returns 0xAAAA0000 + word address.
module tb_dcache_nway;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ren = 1'b0, wen = 1'b0, halt = 1'b0, sel = 1'b0;
  logic [31:0] addr = '0, store = '0;
  int          checks = 0, failures = 0;
  int          wait_cfg = 0, wctr = 0, wcnt4 = 0;
  logic        both_err = 1'b0;
  logic [63:0] wlog[$];
  logic [31:0] rlog[$];

  dcache_nway_if b0();
  dcache_nway_if b4();

  assign b0.dmemREN = ren;   assign b4.dmemREN = ren;
  assign b0.dmemWEN = wen;   assign b4.dmemWEN = wen;
  assign b0.dmemaddr = addr; assign b4.dmemaddr = addr;
  assign b0.dmemstore = store; assign b4.dmemstore = store;
  assign b0.halt = halt;     assign b4.halt = halt;
  assign b0.dwait = (b0.dREN || b0.dWEN) && (wctr < wait_cfg);
  assign b0.dload = 32'hAAAA0000 + (b0.daddr >> 2);
  assign b4.dwait = 1'b0;
  assign b4.dload = 32'hAAAA0000 + (b4.daddr >> 2);

  dcache_nway #(.SETS(8), .WAYS(2), .WORDS_PER_BLK(2), .CNT_ADDR(32'h00003100))
    u0 (.CLK(clk), .RST(rst), .bus(b0));
  dcache_nway #(.SETS(8), .WAYS(4), .WORDS_PER_BLK(2), .CNT_ADDR(32'h00003100))
    u4 (.CLK(clk), .RST(rst), .bus(b4));

  logic        dhit_s;
  logic [31:0] load_s;
  assign dhit_s = sel ? b4.dhit : b0.dhit;
  assign load_s = sel ? b4.dmemload : b0.dmemload;

  always @(posedge clk) begin
    if ((b0.dREN || b0.dWEN) && b0.dwait) wctr <= wctr + 1;
    else wctr <= 0;
    if (b0.dWEN && !b0.dwait) wlog.push_back({b0.daddr, b0.dstore});
    if (b0.dREN && !b0.dwait) rlog.push_back(b0.daddr);
    if (b4.dWEN) wcnt4 <= wcnt4 + 1;
    if ((b0.dREN && b0.dWEN) || (b4.dREN && b4.dWEN)) both_err <= 1'b1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ren = 1'b0; wen = 1'b0; halt = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns cycles from request to dhit (request cycle = 0); 60 means no hit.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        output int cyc, output logic [31:0] rd);
    logic done;
    done = 1'b0; rd = '0; cyc = 0;
    @(negedge clk);
    ren = !wr; wen = wr; addr = a; store = wd;
    while (!done && cyc < 60) begin
      #1;
      if (dhit_s) begin done = 1'b1; rd = load_s; end
      else begin cyc++; @(negedge clk); end
    end
    @(posedge clk); #1;
    ren = 1'b0; wen = 1'b0;
  endtask

  // Halts and returns cycles from halt to flushed (halt cycle = 0).
  task automatic run_halt(output int n);
    @(negedge clk);
    halt = 1'b1; n = 0;
    #1;
    while (!b0.flushed && n < 200) begin
      @(negedge clk); #1; n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if (b0.dhit !== 1'b0 || b0.dmemload !== 32'h0 || b0.flushed !== 1'b0) begin
      failures++; $display("FAIL reset_dp dhit=%b load=%h flushed=%b, want 0/0/0", b0.dhit, b0.dmemload, b0.flushed);
    end
    checks++;
    if (b0.dREN !== 1'b0 || b0.dWEN !== 1'b0 || b0.daddr !== 32'h0 || b0.dstore !== 32'h0) begin
      failures++; $display("FAIL reset_mem dREN=%b dWEN=%b daddr=%h dstore=%h, want zeros", b0.dREN, b0.dWEN, b0.daddr, b0.dstore);
    end
    do_reset();
  endtask

  task automatic test_read_miss();
    int cyc, n, wb, rb;
    logic [31:0] rd;
    do_reset();
    rb = rlog.size();
    access(1'b0, 32'h0, 32'h0, cyc, rd);
    checks++;
    if (cyc !== 3 || rd !== 32'hAAAA0000) begin
      failures++; $display("FAIL miss_latency cyc=%0d load=%h, want 3/aaaa0000", cyc, rd);
    end
    checks++;
    if (rlog.size() - rb !== 2 || rlog[rb] !== 32'h0 || rlog[rb+1] !== 32'h4) begin
      failures++; $display("FAIL miss_fill_addrs n=%0d, want 2 reads 0x0,0x4", rlog.size() - rb);
    end
    access(1'b0, 32'h4, 32'h0, cyc, rd);
    checks++;
    if (cyc !== 0 || rd !== 32'hAAAA0001) begin
      failures++; $display("FAIL hit_word1 cyc=%0d load=%h, want 0/aaaa0001", cyc, rd);
    end
    wb = wlog.size();
    run_halt(n);
    checks++;
    if (n !== 19) begin
      failures++; $display("FAIL clean_flush_cycles got=%0d want=19", n);
    end
    checks++;
    if (wlog.size() - wb !== 2 || wlog[wb] !== {32'h3100, 32'd1} || wlog[wb+1] !== {32'h3104, 32'd1}) begin
      failures++; $display("FAIL counts_1_1 n=%0d, want hits=1 misses=1", wlog.size() - wb);
    end
    halt = 1'b0;
  endtask

  task automatic test_lru_wb();
    int cyc, wb, rb;
    logic [31:0] rd;
    do_reset();
    access(1'b1, 32'h0, 32'h11, cyc, rd);
    access(1'b0, 32'h0, 32'h0, cyc, rd);
    checks++;
    if (cyc !== 0 || rd !== 32'h11) begin
      failures++; $display("FAIL write_then_read cyc=%0d load=%h, want 0/00000011", cyc, rd);
    end
    access(1'b0, 32'h40, 32'h0, cyc, rd);
    checks++;
    if (cyc !== 3 || rd !== 32'hAAAA0010) begin
      failures++; $display("FAIL fill_invalid_way cyc=%0d load=%h, want 3/aaaa0010", cyc, rd);
    end
    wb = wlog.size(); rb = rlog.size();
    access(1'b0, 32'h80, 32'h0, cyc, rd);
    checks++;
    if (cyc !== 5 || rd !== 32'hAAAA0020) begin
      failures++; $display("FAIL dirty_miss cyc=%0d load=%h, want 5/aaaa0020", cyc, rd);
    end
    checks++;
    if (wlog.size() - wb !== 2 || wlog[wb] !== {32'h0, 32'h11} || wlog[wb+1] !== {32'h4, 32'hAAAA0001}) begin
      failures++; $display("FAIL lru_writeback n=%0d, want 0x0=11 0x4=aaaa0001", wlog.size() - wb);
    end
    checks++;
    if (rlog.size() - rb !== 2 || rlog[rb] !== 32'h80 || rlog[rb+1] !== 32'h84) begin
      failures++; $display("FAIL lru_fill n=%0d, want reads 0x80,0x84", rlog.size() - rb);
    end
  endtask

  task automatic test_fill_wait();
    int n, first, hold_err, rb;
    logic prev_ren, prev_wait;
    logic [31:0] prev_addr, rd;
    do_reset();
    wait_cfg = 3; rb = rlog.size();
    first = -1; hold_err = 0; n = 0; rd = '0;
    prev_ren = 1'b0; prev_wait = 1'b0; prev_addr = '0;
    @(negedge clk);
    ren = 1'b1; addr = 32'h100;
    while (first < 0 && n < 40) begin
      #1;
      if (prev_ren && prev_wait && (b0.dREN !== 1'b1 || b0.daddr !== prev_addr)) hold_err++;
      if (b0.dhit) begin first = n; rd = b0.dmemload; end
      prev_ren = b0.dREN; prev_wait = b0.dwait; prev_addr = b0.daddr;
      if (first < 0) begin n++; @(negedge clk); end
    end
    @(posedge clk); #1;
    ren = 1'b0; wait_cfg = 0;
    checks++;
    if (first !== 9 || rd !== 32'hAAAA0040) begin
      failures++; $display("FAIL wait_latency cyc=%0d load=%h, want 9/aaaa0040", first, rd);
    end
    checks++;
    if (hold_err !== 0) begin
      failures++; $display("FAIL wait_hold unstable_cycles=%0d want=0", hold_err);
    end
    checks++;
    if (rlog.size() - rb !== 2 || rlog[rb] !== 32'h100 || rlog[rb+1] !== 32'h104) begin
      failures++; $display("FAIL wait_fill_addrs n=%0d, want 0x100,0x104", rlog.size() - rb);
    end
  endtask

  task automatic test_flush();
    int cyc, n, wb, bad;
    logic [31:0] rd;
    logic [63:0] exp[6];
    do_reset();
    access(1'b0, 32'h0, 32'h0, cyc, rd);
    access(1'b1, 32'h40, 32'h22, cyc, rd);
    access(1'b1, 32'h38, 32'h33, cyc, rd);
    access(1'b0, 32'h44, 32'h0, cyc, rd);
    checks++;
    if (cyc !== 0 || rd !== 32'hAAAA0011) begin
      failures++; $display("FAIL flush_prep_hit cyc=%0d load=%h, want 0/aaaa0011", cyc, rd);
    end
    exp[0] = {32'h40, 32'h22};   exp[1] = {32'h44, 32'hAAAA0011};
    exp[2] = {32'h38, 32'h33};   exp[3] = {32'h3C, 32'hAAAA000F};
    exp[4] = {32'h3100, 32'd1};  exp[5] = {32'h3104, 32'd3};
    wb = wlog.size();
    run_halt(n);
    checks++;
    if (n !== 21) begin
      failures++; $display("FAIL dirty_flush_cycles got=%0d want=21", n);
    end
    bad = (wlog.size() - wb !== 6) ? 1 : 0;
    if (bad == 0)
      for (int i = 0; i < 6; i++) if (wlog[wb+i] !== exp[i]) bad++;
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL flush_writes n=%0d bad=%0d, want 6 ordered writes", wlog.size() - wb, bad);
    end
    @(negedge clk);
    halt = 1'b0; ren = 1'b1; addr = 32'h44;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (b0.dhit !== 1'b0 || b0.flushed !== 1'b1 || b0.dWEN !== 1'b0 || b0.dREN !== 1'b0) bad++;
      @(negedge clk);
    end
    ren = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL done_hold bad_cycles=%0d want=0", bad);
    end
  endtask

  task automatic test_rst_mid_wb();
    int cyc, wb;
    logic [31:0] rd;
    do_reset();
    access(1'b1, 32'h0, 32'h11, cyc, rd);
    access(1'b0, 32'h40, 32'h0, cyc, rd);
    wb = wlog.size();
    @(negedge clk);
    ren = 1'b1; addr = 32'h80;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (b0.dWEN !== 1'b1 || b0.daddr !== 32'h4) begin
      failures++; $display("FAIL wb_word2 dWEN=%b daddr=%h, want 1/00000004", b0.dWEN, b0.daddr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (b0.dWEN !== 1'b0 || b0.dREN !== 1'b0 || b0.daddr !== 32'h0) begin
      failures++; $display("FAIL rst_drops_strobe dWEN=%b dREN=%b daddr=%h, want 0/0/0", b0.dWEN, b0.dREN, b0.daddr);
    end
    ren = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    checks++;
    if (wlog.size() - wb !== 1) begin
      failures++; $display("FAIL abandoned_wb writes=%0d want=1", wlog.size() - wb);
    end
    access(1'b0, 32'h0, 32'h0, cyc, rd);
    checks++;
    if (cyc !== 3 || rd !== 32'hAAAA0000) begin
      failures++; $display("FAIL post_rst_miss0 cyc=%0d load=%h, want 3/aaaa0000", cyc, rd);
    end
    access(1'b0, 32'h40, 32'h0, cyc, rd);
    checks++;
    if (cyc !== 3 || b0.flushed !== 1'b0) begin
      failures++; $display("FAIL post_rst_miss1 cyc=%0d flushed=%b, want 3/0", cyc, b0.flushed);
    end
  endtask

  task automatic test_four_way();
    int cyc, c0, bad;
    logic [31:0] rd;
    logic [31:0] tg[4];
    sel = 1'b1;
    do_reset();
    c0 = wcnt4; bad = 0;
    tg[0] = 32'h0; tg[1] = 32'h40; tg[2] = 32'h80; tg[3] = 32'hC0;
    for (int i = 0; i < 4; i++) begin
      access(1'b0, tg[i], 32'h0, cyc, rd);
      if (cyc !== 3) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL four_way_fills slow=%0d want=0", bad);
    end
    bad = 0;
    access(1'b0, 32'h0, 32'h0, cyc, rd);  if (cyc !== 0) bad++;
    access(1'b0, 32'h80, 32'h0, cyc, rd); if (cyc !== 0) bad++;
    access(1'b0, 32'hC0, 32'h0, cyc, rd); if (cyc !== 0) bad++;
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL four_way_touch misses=%0d want=0", bad);
    end
    access(1'b0, 32'h100, 32'h0, cyc, rd);
    checks++;
    if (cyc !== 3 || rd !== 32'hAAAA0040) begin
      failures++; $display("FAIL four_way_newtag cyc=%0d load=%h, want 3/aaaa0040", cyc, rd);
    end
    bad = 0;
    access(1'b0, 32'h0, 32'h0, cyc, rd);  if (cyc !== 0) bad++;
    access(1'b0, 32'h80, 32'h0, cyc, rd); if (cyc !== 0) bad++;
    access(1'b0, 32'hC0, 32'h0, cyc, rd); if (cyc !== 0) bad++;
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL four_way_survivors misses=%0d want=0", bad);
    end
    access(1'b0, 32'h40, 32'h0, cyc, rd);
    checks++;
    if (cyc !== 3) begin
      failures++; $display("FAIL four_way_victim_tag1 cyc=%0d want=3", cyc);
    end
    checks++;
    if (wcnt4 - c0 !== 0) begin
      failures++; $display("FAIL four_way_no_wb writes=%0d want=0", wcnt4 - c0);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_lru_wb();
    test_fill_wait();
    test_flush();
    test_rst_mid_wb();
    test_four_way();
    checks++;
    if (both_err !== 1'b0) begin
      failures++; $display("FAIL strobe_exclusive both_high=%b want=0", both_err);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
